// File: rtl/plru_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plru_pkg
// Brief    : Shared width constants and heap path/leaf helpers for tree-PLRU
//            replacement logic and sibling arbiter blocks.
// Revision : 1.0 - initial release
// ============================================================================
package plru_pkg;

  localparam int PLRU_MAX_WAYS   = 64;
  localparam int PLRU_MAX_WAY_W  = 6;
  localparam int PLRU_MAX_NODES  = PLRU_MAX_WAYS - 1;
  localparam int PLRU_NODE_IDX_W = 6;

  typedef logic [PLRU_MAX_NODES-1:0] plru_nodes_t;

  // Heap index of the node visited at 'level' on the way to leaf 'way'.
  function automatic int plru_path_node(input int level, input int way, input int way_w);
    return ((1 << level) - 1) + (way >> (way_w - level));
  endfunction

  // Node value that marks the branch toward 'way' as most recent.
  function automatic logic plru_path_dir(input int level, input int way, input int way_w);
    return ((way >> (way_w - 1 - level)) & 1) == 0;
  endfunction

  function automatic int plru_leaf_node(input int way, input int ways);
    return ways - 1 + way;
  endfunction

  function automatic int plru_leaf_way(input int leaf, input int ways);
    return leaf - (ways - 1);
  endfunction

  // Promote 'way' to MRU: rewrite every node on its root-to-leaf path.
  function automatic plru_nodes_t plru_touch(input plru_nodes_t nodes, input int way,
                                             input int way_w);
    plru_nodes_t r;
    r = nodes;
    for (int l = 0; l < PLRU_MAX_WAY_W; l++) begin
      if (l < way_w) begin
        r[PLRU_NODE_IDX_W'(plru_path_node(l, way, way_w))] = plru_path_dir(l, way, way_w);
      end
    end
    return r;
  endfunction

endpackage : plru_pkg
`default_nettype wire

// File: rtl/plru_victim_walk.sv
`default_nettype none
// ============================================================================
// Module   : plru_victim_walk
// Brief    : Combinational tree walk from node bits and lock mask to a victim.
// Revision : 1.0 - initial release
// ============================================================================
module plru_victim_walk
  import plru_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  nodes,
  input  logic [WAYS-1:0]  lock_mask,
  output logic [WAY_W-1:0] way,
  output logic             none
);

  // Internal nodes followed by leaves, all in one heap-indexed vector.
  localparam int HEAP_N = 2 * WAYS - 1;
  localparam int IDX_W  = $clog2(HEAP_N);

  typedef logic [HEAP_N-1:0] heap_t;

  function automatic heap_t subtree_locked(input logic [WAYS-1:0] m);
    heap_t f;
    f = '0;
    f[HEAP_N-1:WAYS-1] = m;
    for (int n = WAYS - 2; n >= 0; n--) begin
      f[IDX_W'(n)] = f[IDX_W'(2 * n + 1)] & f[IDX_W'(2 * n + 2)];
    end
    return f;
  endfunction

  // A fully locked preferred subtree diverts the walk to its sibling.
  function automatic logic [WAY_W-1:0] walk(input heap_t nb, input heap_t full);
    logic [IDX_W-1:0] cur;
    logic             go_right;
    cur = '0;
    for (int l = 0; l < WAY_W; l++) begin
      go_right = nb[cur];
      if (go_right && full[IDX_W'(2 * cur + 2)]) begin
        go_right = 1'b0;
      end else if (!go_right && full[IDX_W'(2 * cur + 1)]) begin
        go_right = 1'b1;
      end
      cur = go_right ? IDX_W'(2 * cur + 2) : IDX_W'(2 * cur + 1);
    end
    return WAY_W'(plru_leaf_way(int'(cur), WAYS));
  endfunction

  heap_t full;
  heap_t node_ext;

  always_comb begin
    full     = subtree_locked(lock_mask);
    node_ext = {{WAYS{1'b0}}, nodes};
    none     = full[0];
    way      = full[0] ? '0 : walk(node_ext, full);
  end

endmodule : plru_victim_walk
`default_nettype wire

// File: rtl/plru_replace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : plru_replace_ctrl
// Brief    : Per-set tree-PLRU state with hit touch and victim request/response.
//            Define PLRU_LOCK_EN to add lock_mask and locked-way exclusion.
// Revision : 1.0 - initial release
// ============================================================================
module plru_replace_ctrl
  import plru_pkg::*;
#(
  parameter  int WAYS     = 4,
  parameter  int NUM_SETS = 16,
  localparam int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WAY_W    = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_vld,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [SET_W-1:0] req_set,
  output logic             vict_vld,
  input  logic             vict_rdy,
  output logic [WAY_W-1:0] vict_way,
  output logic             vict_none
`ifdef PLRU_LOCK_EN
  ,
  input  logic [WAYS-1:0]  lock_mask
`endif
);

  localparam int NODES = WAYS - 1;

  logic [NODES-1:0] tree     [NUM_SETS];
  logic [NODES-1:0] tree_nxt [NUM_SETS];
  logic [NODES-1:0] req_nodes;
  logic [WAYS-1:0]  walk_lock;
  logic [WAY_W-1:0] walk_way;
  logic             walk_none;
  logic [WAY_W-1:0] next_way;
  logic             next_none;
  logic             req_in_range;
  logic             accept;
  logic             alloc;

`ifdef PLRU_LOCK_EN
  assign walk_lock = lock_mask;
`else
  assign walk_lock = '0;
`endif

  assign req_rdy      = ~vict_vld | vict_rdy;
  assign accept       = req_vld & req_rdy;
  assign req_in_range = int'(req_set) < NUM_SETS;

  always_comb begin
    req_nodes = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      if (req_set == SET_W'(s)) begin
        req_nodes = tree[s];
      end
    end
  end

  plru_victim_walk #(
    .WAYS (WAYS)
  ) u_walk (
    .nodes     (req_nodes),
    .lock_mask (walk_lock),
    .way       (walk_way),
    .none      (walk_none)
  );

  assign next_none = ~req_in_range | walk_none;
  assign next_way  = next_none ? '0 : walk_way;
  assign alloc     = accept & ~next_none;

  // Allocate-touch first, then the explicit touch, so the hit wins shared nodes.
  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    plru_nodes_t work;
    always_comb begin
      work = '0;
      work[NODES-1:0] = tree[s];
      if (alloc && req_set == SET_W'(s)) begin
        work = plru_touch(work, int'(walk_way), WAY_W);
      end
      if (touch_vld && touch_set == SET_W'(s)) begin
        work = plru_touch(work, int'(touch_way), WAY_W);
      end
    end
    assign tree_nxt[s] = work[NODES-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree <= '{default: '0};
    end else begin
      tree <= tree_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vict_vld  <= 1'b0;
      vict_way  <= '0;
      vict_none <= 1'b0;
    end else if (accept) begin
      vict_vld  <= 1'b1;
      vict_way  <= next_way;
      vict_none <= next_none;
    end else if (vict_rdy) begin
      vict_vld  <= 1'b0;
    end
  end

endmodule : plru_replace_ctrl
`default_nettype wire

// File: tb/tb_plru_replace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_plru_replace_ctrl
// Brief    : Scoreboard bench for plru_replace_ctrl against an interval-based
//            PLRU reference model; directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plru_replace_ctrl;

  localparam int WAYS     = 4;
  localparam int NUM_SETS = 12;
  localparam int SET_W    = 4;
  localparam int WAY_W    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             touch_vld = 1'b0;
  logic [SET_W-1:0] touch_set = '0;
  logic [WAY_W-1:0] touch_way = '0;
  logic             req_vld = 1'b0;
  logic             req_rdy;
  logic [SET_W-1:0] req_set = '0;
  logic             vict_vld;
  logic             vict_rdy = 1'b1;
  logic [WAY_W-1:0] vict_way;
  logic             vict_none;
  logic [WAYS-1:0]  lock_mask = '0;

  plru_replace_ctrl #(
    .WAYS     (WAYS),
    .NUM_SETS (NUM_SETS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .touch_vld (touch_vld),
    .touch_set (touch_set),
    .touch_way (touch_way),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_set   (req_set),
    .vict_vld  (vict_vld),
    .vict_rdy  (vict_rdy),
    .vict_way  (vict_way),
    .vict_none (vict_none)
`ifdef PLRU_LOCK_EN
    ,
    .lock_mask (lock_mask)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit exp_rdy = 1'b1;
  bit m_vld   = 1'b0;
  bit mon_en  = 1'b0;

  // Reference: per-set node bits, walked by halving way intervals.
  bit m_node [NUM_SETS][WAYS-1];

  typedef struct {
    int way;
    bit none;
    int cyc;
  } resp_t;
  resp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit all_locked(input logic [WAYS-1:0] lk, input int lo, input int hi);
    for (int i = lo; i < hi; i++) if (!lk[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_victim(input int s, input logic [WAYS-1:0] lk,
                                   output int way, output bit none);
    int lo, hi, n, mid;
    bit right;
    way = 0;
    none = 1'b1;
    if (s >= NUM_SETS || all_locked(lk, 0, WAYS)) return;
    lo = 0; hi = WAYS; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      right = m_node[s][n];
      if (right && all_locked(lk, mid, hi)) right = 1'b0;
      else if (!right && all_locked(lk, lo, mid)) right = 1'b1;
      if (right) begin lo = mid; n = 2 * n + 2; end
      else       begin hi = mid; n = 2 * n + 1; end
    end
    way = lo;
    none = 1'b0;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int lo, hi, n, mid;
    if (s >= NUM_SETS) return;
    lo = 0; hi = WAYS; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_node[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
      else         begin m_node[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
    end
  endfunction

  task automatic m_reset();
    for (int s = 0; s < NUM_SETS; s++)
      for (int n = 0; n < WAYS - 1; n++) m_node[s][n] = 1'b0;
    sbq.delete();
    m_vld = 1'b0;
    exp_rdy = 1'b1;
  endtask

  task automatic step(input bit rv, input int rs, input bit tv, input int ts, input int tw,
                      input bit vr, input logic [WAYS-1:0] lk);
    int w;
    bit n;
    bit acc;
    @(posedge clk);
    #1;
    cyc++;
    req_vld = rv; req_set = SET_W'(rs);
    touch_vld = tv; touch_set = SET_W'(ts); touch_way = WAY_W'(tw);
    vict_rdy = vr; lock_mask = lk;
    exp_rdy = !m_vld || vr;
    acc = rv && exp_rdy;
    if (acc) begin
      m_victim(rs, lk, w, n);
      sbq.push_back('{way: w, none: n, cyc: cyc});
      if (!n) m_touch(rs, w);
    end
    if (tv) m_touch(ts, tw);
    m_vld = acc || (m_vld && !vr);
  endtask

  task automatic step_idle();
    step(1'b0, 0, 1'b0, 0, 0, 1'b1, '0);
  endtask

  task automatic wait_resp(input int exp_way, input bit exp_none, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      step_idle();
      @(negedge clk);
      if (vict_vld) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({name, "_way"}, 32'(vict_way), 32'(exp_way));
      chk({name, "_none"}, 32'(vict_none), 32'(exp_none));
    end
  endtask

  task automatic req_expect(input int s, input logic [WAYS-1:0] lk, input int exp_way,
                            input bit exp_none, input string name);
    step(1'b1, s, 1'b0, 0, 0, 1'b1, lk);
    wait_resp(exp_way, exp_none, name);
  endtask

  always @(negedge clk) begin
    bit ev;
    if (mon_en && !rst) begin
      ev = (sbq.size() > 0) && (sbq[0].cyc < cyc);
      chk("mon_vict_vld", 32'(vict_vld), 32'(ev));
      chk("mon_req_rdy", 32'(req_rdy), 32'(exp_rdy));
      if (ev) begin
        chk("mon_vict_way", 32'(vict_way), 32'(sbq[0].way));
        chk("mon_vict_none", 32'(vict_none), 32'(sbq[0].none));
        if (vict_rdy) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vict_vld", 32'(vict_vld), 32'd0);
    chk("rst_vict_way", 32'(vict_way), 32'd0);
    chk("rst_vict_none", 32'(vict_none), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    #3 rst = 1'b0;
    mon_en = 1'b1;

    // Allocation sequence on a fresh set.
    req_expect(3, '0, 0, 1'b0, "seq_a");
    req_expect(3, '0, 2, 1'b0, "seq_b");
    req_expect(3, '0, 1, 1'b0, "seq_c");
    req_expect(3, '0, 3, 1'b0, "seq_d");

    // Hits steer the victim; neighbouring set untouched.
    step(1'b0, 0, 1'b1, 5, 0, 1'b1, '0);
    step(1'b0, 0, 1'b1, 5, 2, 1'b1, '0);
    req_expect(5, '0, 1, 1'b0, "touch_set5");
    req_expect(6, '0, 0, 1'b0, "touch_set6");

    // Out-of-range set answers with none and changes nothing.
    step(1'b0, 0, 1'b1, 14, 3, 1'b1, '0);
    req_expect(13, '0, 0, 1'b1, "oor_req");

    // Backpressure: response held, request blocked, then accepted.
    step(1'b1, 7, 1'b0, 0, 0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8, 1'b0, 0, 0, 1'b0, '0);
      #2;
      chk("stall_req_rdy", 32'(req_rdy), 32'd0);
      chk("stall_vict_way", 32'(vict_way), 32'd0);
    end
    step(1'b1, 8, 1'b0, 0, 0, 1'b1, '0);
    #2;
    chk("release_req_rdy", 32'(req_rdy), 32'd1);
    wait_resp(0, 1'b0, "release_set8");

    // Same-set request and touch in one cycle.
    step(1'b1, 2, 1'b1, 2, 2, 1'b1, '0);
    wait_resp(0, 1'b0, "same_a");
    req_expect(2, '0, 1, 1'b0, "same_b");

`ifdef PLRU_LOCK_EN
    req_expect(9, 4'b0011, 2, 1'b0, "lock_a");
    req_expect(9, 4'b0011, 3, 1'b0, "lock_b");
    req_expect(9, 4'b0011, 2, 1'b0, "lock_c");
    req_expect(9, 4'b1111, 0, 1'b1, "lock_all");
    req_expect(9, 4'b0000, 0, 1'b0, "lock_after");
`endif

    // Asynchronous reset while a response is pending.
    step(1'b1, 4, 1'b0, 0, 0, 1'b0, '0);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, '0);
    #2;
    chk("pre_rst_vld", 32'(vict_vld), 32'd1);
    rst = 1'b1;
    req_vld = 1'b0; touch_vld = 1'b0; vict_rdy = 1'b1;
    m_reset();
    #1;
    chk("async_rst_vld", 32'(vict_vld), 32'd0);
    chk("async_rst_way", 32'(vict_way), 32'd0);
    chk("async_rst_none", 32'(vict_none), 32'd0);
    chk("async_rst_rdy", 32'(req_rdy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst_rdy", 32'(req_rdy), 32'd1);
    #2 rst = 1'b0;
    for (int s = 0; s < NUM_SETS; s++) req_expect(s, '0, 0, 1'b0, "post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [WAYS-1:0] lk;
      lk = '0;
`ifdef PLRU_LOCK_EN
      if ($urandom_range(0, 3) == 0) lk = WAYS'($urandom);
`endif
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, WAYS - 1)), $urandom_range(0, 9) < 7, lk);
    end

    for (int k = 0; k < 8 && sbq.size() > 0; k++) step_idle();
    @(negedge clk);
    chk("drain_queue", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_plru_replace_ctrl
`default_nettype wire

// File: doc/plru_replace_ctrl.md
PLRU_REPLACE_CTRL -- requirements
Module: plru_replace_ctrl

Interface
REQ-001 SHALL have parameter WAYS, default 4: ways per set; power of two, >=2.
REQ-002 SHALL have parameter NUM_SETS, default 16: independent PLRU trees, >=1.
REQ-003 SHALL have parameters SET_W = max(1,clog2(NUM_SETS)) and WAY_W = clog2(WAYS), derived, not overridden.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 touch_vld  in  1  hit access; promote touch_way to MRU in touch_set.
REQ-007 touch_set  in  SET_W; touch_way  in  WAY_W.
REQ-008 req_vld  in  1; req_rdy  out  1; req_set  in  SET_W: victim request, valid/ready handshake.
REQ-009 vict_vld  out  1; vict_rdy  in  1; vict_way  out  WAY_W; vict_none  out  1: victim response, valid/ready handshake.
REQ-010 lock_mask  in  WAYS  per-way lock, applied to every set (present only with PLRU_LOCK_EN).

Function
REQ-011 Each set SHALL hold WAYS-1 node bits in heap order (node 0 root; children of n are 2n+1, 2n+2; leaf pairs map ways 2k, 2k+1).
REQ-012 Node=1 SHALL mean left subtree more recent (victim walk goes right); node=0 walk goes left.
REQ-013 Touch of way w SHALL set every node on w's root-to-leaf path to 1 if w is in its left subtree, else 0; off-path nodes unchanged; 1-cycle effect.
REQ-014 Request accepted when req_vld && req_rdy; req_rdy = ~vict_vld | vict_rdy (combinational, no req_vld dependency).
REQ-015 On acceptance the victim SHALL be computed from the set's current (pre-edge) state and registered; vict_vld asserts the next cycle (latency 1).
REQ-016 On acceptance with vict_none=0, the victim way SHALL be promoted to MRU in req_set at the same edge (allocate-touch).
REQ-017 vict_way/vict_none SHALL hold stable while vict_vld && ~vict_rdy; back-to-back acceptance allowed every cycle when vict_rdy=1.
REQ-018 Touch and allocate-touch to different sets in one cycle SHALL both apply.
REQ-019 Same set same cycle: allocate-touch applied first, explicit touch applied second (touch wins on shared nodes); victim still from pre-edge state.
REQ-020 Out-of-range touch_set/req_set (>=NUM_SETS) SHALL be ignored for state update; request still answered with vict_way=0, vict_none=1.
REQ-021 Without locks, vict_none SHALL be 0 for every in-range request.

Reset
REQ-022 rst SHALL asynchronously clear all node bits of all sets to 0, vict_vld=0, vict_way=0, vict_none=0.
REQ-023 Response pending at rst assertion SHALL be discarded; req_rdy=1 while rst is asserted and the cycle after release.
REQ-024 First request after reset to any set SHALL return way 0.

Configuration
REQ-025 Macro PLRU_LOCK_EN SHALL add port lock_mask and locked-way exclusion.
REQ-026 With PLRU_LOCK_EN: at each node, if preferred subtree is fully locked the walk SHALL take the other subtree; if all ways locked, vict_none=1, vict_way=0, no state update.
REQ-027 Without PLRU_LOCK_EN: no lock_mask port, walk follows node bits only, vict_none driven by REQ-020 only.

Structure
REQ-028 Package plru_pkg SHALL hold path/leaf index helper functions and width constants shared with sibling arbiter blocks.
REQ-029 Combinational tree walk (node vector + optional lock mask -> way, none) SHALL be sub-module plru_victim_walk, instantiated once.
REQ-030 State storage SHALL be flops, NUM_SETS x (WAYS-1) bits; no RAM.

Verification
REQ-031 Reset, WAYS=4: req set 3 -> vict_way=0; req set 3 again -> vict_way=2; again -> 1; again -> 3.
REQ-032 Touch set 5 way 0, then way 2 -> req set 5 returns way 1; set 6 unaffected (returns 0).
REQ-033 vict_rdy=0 for 3 cycles with vict_vld=1 -> req_rdy=0, vict_way stable; vict_rdy=1 -> next request accepted same cycle.
REQ-034 Same cycle req set 2 + touch set 2 way 2 from reset -> vict_way=0; following req set 2 returns way 1 (touch on root won).
REQ-035 PLRU_LOCK_EN, lock_mask=4'b0011 from reset -> victim 2, then 3, then 2; lock_mask=4'b1111 -> vict_none=1, state unchanged.
REQ-036 Assert rst while vict_vld=1 -> vict_vld=0 immediately (async); after release all sets return way 0.
